// File: rtl/alu_mseq_if.sv
// Request/response channel of alu_mseq: operands in, one result (or fault) out.
interface alu_mseq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             fault;

    modport master (
        output in_valid, op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out, fault
    );

    modport slave (
        input  in_valid, op, in_a, in_b, out_ready,
        output in_ready, out_valid, out, fault
    );
endinterface

// File: rtl/alu_mseq.sv
// Handshaked integer ALU: registered single-cycle base/branch ops plus
// iterative (one bit per cycle) RV32M multiply, divide and remainder.
module alu_mseq #(
    parameter int unsigned WIDTH    = 32,
    parameter bit          ENABLE_M = 1'b1
) (
    input  logic      clk,
    input  logic      reset_n,
    alu_mseq_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned W2  = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             fault_q, fault_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [2:0]       func_q, func_d;
    logic             neg_q, neg_d;

    logic [WIDTH-1:0] a, b;
    logic [SHW-1:0]   shamt;
    logic             eq, lt_s, lt_u;
    logic [WIDTH-1:0] base_res;
    logic             base_ok;

    assign a     = bus.in_a;
    assign b     = bus.in_b;
    assign shamt = b[SHW-1:0];
    assign eq    = (a == b);
    assign lt_s  = ($signed(a) < $signed(b));
    assign lt_u  = (a < b);

    // Base and branch-compare result, computed from the live request.
    always_comb begin
        base_res = '0;
        base_ok  = 1'b1;
        case (bus.op[4:0])
            5'b00000: base_res = a + b;
            5'b01000: base_res = a + ~b + WIDTH'(1);
            5'b00001: base_res = a << shamt;
            5'b00101: base_res = a >> shamt;
            5'b01101: base_res = WIDTH'($signed(a) >>> shamt);
            5'b00010: base_res = WIDTH'(lt_s);
            5'b00011: base_res = WIDTH'(lt_u);
            5'b00100: base_res = a ^ b;
            5'b00110: base_res = a | b;
            5'b00111: base_res = a & b;
            5'b10000: base_res = WIDTH'(eq);
            5'b10001: base_res = WIDTH'(!eq);
            5'b10100: base_res = WIDTH'(lt_s);
            5'b10101: base_res = WIDTH'(!lt_s);
            5'b10110: base_res = WIDTH'(lt_u);
            5'b10111: base_res = WIDTH'(!lt_u);
            default:  base_ok  = 1'b0;
        endcase
    end

    logic [2:0]       mfunc;
    logic             m_ok, sa, sb, m_neg;
    logic [WIDTH-1:0] opa, opb;
    logic             div_zero, div_ovf, m_special;
    logic [WIDTH-1:0] special_res;

    // M-op setup: operand magnitudes, final sign and the no-iteration division cases.
    always_comb begin
        mfunc       = bus.op[2:0];
        m_ok        = ENABLE_M && (bus.op[4:3] == 2'b00);
        sa          = (mfunc == 3'b001) || (mfunc == 3'b010) || (mfunc == 3'b100) || (mfunc == 3'b110);
        sb          = (mfunc == 3'b001) || (mfunc == 3'b100) || (mfunc == 3'b110);
        opa         = (sa && a[WIDTH-1]) ? -a : a;
        opb         = (sb && b[WIDTH-1]) ? -b : b;
        m_neg       = (mfunc == 3'b110) ? (sa && a[WIDTH-1])
                                        : ((sa && a[WIDTH-1]) ^ (sb && b[WIDTH-1]));
        div_zero    = (b == '0);
        div_ovf     = !mfunc[0] && (a == MIN_NEG) && (b == '1);
        m_special   = mfunc[2] && (div_zero || div_ovf);
        special_res = '0;
        if (div_zero) begin
            special_res = mfunc[1] ? a : '1;
        end else if (!mfunc[1]) begin
            special_res = a;
        end
    end

    logic [WIDTH:0]   mul_sum, div_trial;
    logic [W2-1:0]    mul_next, div_next, step, prod;
    logic [WIDTH-1:0] div_sel, m_result;

    // One iteration: acc holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_trial = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opnd_q};
        div_next  = div_trial[WIDTH] ? {acc_q[W2-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        step      = func_q[2] ? div_next : mul_next;
        prod      = neg_q ? -step : step;
        div_sel   = func_q[1] ? step[W2-1:WIDTH] : step[WIDTH-1:0];
        m_result  = '0;
        if (func_q[2]) begin
            m_result = neg_q ? -div_sel : div_sel;
        end else if (func_q[1:0] == 2'b00) begin
            m_result = prod[WIDTH-1:0];
        end else begin
            m_result = prod[W2-1:WIDTH];
        end
    end

    logic in_ready_c, accept;

    // Next-state and handshake logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        out_d      = out_q;
        fault_d    = fault_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        func_d     = func_q;
        neg_d      = neg_q;
        in_ready_c = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
        accept     = bus.in_valid && in_ready_c;

        case (state_q)
            BUSY: begin
                acc_d   = step;
                count_d = count_q + SHW'(1);
                if (count_q == SHW'(WIDTH - 1)) begin
                    out_d   = m_result;
                    fault_d = 1'b0;
                    count_d = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        if (accept) begin
            state_d = DONE;
            count_d = '0;
            fault_d = 1'b0;
            if (!bus.op[5]) begin
                out_d   = base_ok ? base_res : '0;
                fault_d = !base_ok;
            end else if (!m_ok) begin
                out_d   = '0;
                fault_d = 1'b1;
            end else if (m_special) begin
                out_d = special_res;
            end else begin
                state_d = BUSY;
                func_d  = mfunc;
                neg_d   = m_neg;
                opnd_d  = mfunc[2] ? opb : opa;
                acc_d   = {{WIDTH{1'b0}}, (mfunc[2] ? opa : opb)};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            out_q   <= '0;
            fault_q <= 1'b0;
            acc_q   <= '0;
            opnd_q  <= '0;
            func_q  <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            out_q   <= out_d;
            fault_q <= fault_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            func_q  <= func_d;
            neg_q   <= neg_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.fault     = fault_q;
endmodule

// File: tb/tb_alu_mseq.sv
// Bench for alu_mseq: random traffic against an arithmetic reference model,
// plus directed literal cases for latency, faults, backpressure and reset.
module tb_alu_mseq;
    logic clk;
    logic reset_n;

    alu_mseq_if #(.WIDTH(32)) bus  ();
    alu_mseq_if #(.WIDTH(32)) bus0 ();

    alu_mseq #(.WIDTH(32), .ENABLE_M(1'b1)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
    alu_mseq #(.WIDTH(32), .ENABLE_M(1'b0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: results straight from the operation definitions using 64-bit arithmetic.
    function automatic void ref_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input bit en_m, output logic [31:0] r, output logic f, output int lat);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        r = '0; f = 1'b0; lat = 1;
        if (!op[5]) begin
            case (op[4:0])
                5'h00: r = a + b;
                5'h08: r = a - b;
                5'h01: r = a << b[4:0];
                5'h05: r = a >> b[4:0];
                5'h0D: r = 32'(sa >>> b[4:0]);
                5'h02: r = (sa < sb) ? 32'd1 : 32'd0;
                5'h03: r = (a < b) ? 32'd1 : 32'd0;
                5'h04: r = a ^ b;
                5'h06: r = a | b;
                5'h07: r = a & b;
                5'h10: r = (a == b) ? 32'd1 : 32'd0;
                5'h11: r = (a != b) ? 32'd1 : 32'd0;
                5'h14: r = (sa < sb) ? 32'd1 : 32'd0;
                5'h15: r = (sa >= sb) ? 32'd1 : 32'd0;
                5'h16: r = (a < b) ? 32'd1 : 32'd0;
                5'h17: r = (a >= b) ? 32'd1 : 32'd0;
                default: f = 1'b1;
            endcase
        end else if (!en_m || op[4:3] != 2'b00) begin
            f = 1'b1;
        end else begin
            lat = 33;
            case (op[2:0])
                3'd0: begin p = 64'(sa * sb); r = p[31:0];  end
                3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
                3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
                3'd3: begin p = 64'(ua * ub); r = p[63:32]; end
                3'd4: if (b == 0) begin r = '1; lat = 1; end
                      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; lat = 1; end
                      else r = 32'(sa / sb);
                3'd5: if (b == 0) begin r = '1; lat = 1; end
                      else r = a / b;
                3'd6: if (b == 0) begin r = a; lat = 1; end
                      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = '0; lat = 1; end
                      else r = 32'(sa % sb);
                default: if (b == 0) begin r = a; lat = 1; end
                         else r = a % b;
            endcase
        end
    endfunction

    // Model of the outstanding result, and per-cycle comparison against the DUT.
    bit          m_pend = 1'b0;
    logic [31:0] m_res;
    logic        m_fault;
    int          m_due;
    bit          exp_valid, exp_ready;
    logic [31:0] nr;
    logic        nf;
    int          nl;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_pend = 1'b0;
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out", bus.out, 32'd0);
            chk("rst_fault", 32'(bus.fault), 32'd0);
        end else begin
            exp_valid = m_pend && (cyc >= m_due);
            exp_ready = !m_pend || (exp_valid && bus.out_ready);
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
            if (exp_valid) begin
                chk("out", bus.out, m_res);
                chk("fault", 32'(bus.fault), 32'(m_fault));
            end
            if (exp_valid && bus.out_ready) m_pend = 1'b0;
            if (bus.in_valid && exp_ready) begin
                ref_model(bus.op, bus.in_a, bus.in_b, 1'b1, nr, nf, nl);
                m_pend  = 1'b1;
                m_res   = nr;
                m_fault = nf;
                m_due   = cyc + nl;
            end
        end
        cyc++;
    end

    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
        logic rdy;
        int   n;
        n = 0;
        bus.in_valid = 1'b1; bus.op = o; bus.in_a = a; bus.in_b = b;
        forever begin
            @(negedge clk); rdy = bus.in_ready;
            @(posedge clk); #1;
            if (rdy) break;
            n++;
            if (n > 200) begin
                chk("issue_timeout", 32'd0, 32'd1);
                break;
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_lit(input string name, input logic [5:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] er, input logic ef, input int elat);
        int lat;
        issue(o, a, b);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk({name, "_lat"}, 32'(lat), 32'(elat));
        chk({name, "_out"}, bus.out, er);
        chk({name, "_fault"}, 32'(bus.fault), 32'(ef));
    endtask

    task automatic drain();
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_0001;
            4: return 32'($urandom_range(0, 20));
            5: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [5:0] ops [24];
    logic [31:0] pr;
    logic        pf;
    int          pl;

    initial begin
        ops = '{6'h00, 6'h08, 6'h01, 6'h05, 6'h0D, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                6'h10, 6'h11, 6'h14, 6'h15, 6'h16, 6'h17,
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27};
        reset_n = 1'b1;
        bus.in_valid = 1'b0; bus.op = '0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
        bus0.in_valid = 1'b0; bus0.op = '0; bus0.in_a = '0; bus0.in_b = '0; bus0.out_ready = 1'b1;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Pin the reference model on hand-computed values.
        ref_model(6'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, pr, pf, pl); chk("model_mulh", pr, 32'h0);
        ref_model(6'h23, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, pr, pf, pl); chk("model_mulhu", pr, 32'hFFFF_FFFE);
        ref_model(6'h24, 32'hFFFF_FFF9, 32'd2, 1'b1, pr, pf, pl);         chk("model_div", pr, 32'hFFFF_FFFD);
        ref_model(6'h26, 32'hFFFF_FFF9, 32'd2, 1'b1, pr, pf, pl);         chk("model_rem", pr, 32'hFFFF_FFFF);
        ref_model(6'h0D, 32'h8000_0000, 32'd4, 1'b1, pr, pf, pl);         chk("model_sra", pr, 32'hF800_0000);

        // Base sweep.
        expect_lit("add",  6'h00, 32'd7, 32'd5, 32'd12, 1'b0, 1);
        expect_lit("sub",  6'h08, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
        expect_lit("sra",  6'h0D, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
        expect_lit("sltu", 6'h03, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1);
        expect_lit("bge",  6'h15, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1);

        // Multiply and divide.
        expect_lit("mulh",  6'h21, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 33);
        expect_lit("mulhu", 6'h23, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
        expect_lit("mul",   6'h20, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4, 1'b0, 33);
        expect_lit("div",   6'h24, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
        expect_lit("rem",   6'h26, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
        expect_lit("divu0", 6'h25, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
        expect_lit("remov", 6'h26, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);

        // Faults, then a clean op.
        expect_lit("flt09", 6'h09, 32'd1, 32'd2, 32'd0, 1'b1, 1);
        expect_lit("flt38", 6'h38, 32'd1, 32'd2, 32'd0, 1'b1, 1);
        expect_lit("postf", 6'h00, 32'd4, 32'd4, 32'd8, 1'b0, 1);

        // Back-to-back base ops, one result per cycle.
        drain();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.op = 6'h00; bus.in_a = 32'(i * 3); bus.in_b = 32'd100;
            @(posedge clk); #1;
            chk("b2b_out", bus.out, 32'(i * 3 + 100));
            chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid = 1'b0;

        // Backpressure on a DIVU result.
        drain();
        bus.out_ready = 1'b0;
        issue(6'h25, 32'd100, 32'd7);
        for (int n = 0; n < 100 && !bus.out_valid; n++) begin
            @(posedge clk); #1;
        end
        chk("bp_first", bus.out, 32'd14);
        bus.in_valid = 1'b1; bus.op = 6'h00; bus.in_a = 32'd2; bus.in_b = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_out", bus.out, 32'd14);
            chk("bp_fault", 32'(bus.fault), 32'd0);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("bp_next", bus.out, 32'd5);

        // Randomised traffic with random backpressure.
        drain();
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = ($urandom_range(0, 1) != 0);
            bus.op        = ($urandom_range(0, 9) < 7) ? ops[$urandom_range(0, 23)] : 6'($urandom);
            bus.in_a      = pick_opnd();
            bus.in_b      = pick_opnd();
        end
        drain();

        // Reset in the middle of a division.
        issue(6'h24, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_out", bus.out, 32'd0);
        chk("abort_fault", 32'(bus.fault), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        expect_lit("post_rst", 6'h00, 32'd1, 32'd1, 32'd2, 1'b0, 1);
        drain();

        // Build without M: every op[5]=1 code faults.
        @(posedge clk); #1;
        bus0.in_valid = 1'b1; bus0.op = 6'h20; bus0.in_a = 32'd3; bus0.in_b = 32'd4;
        @(posedge clk); #1;
        chk("nom_valid", 32'(bus0.out_valid), 32'd1);
        chk("nom_out", bus0.out, 32'd0);
        chk("nom_fault", 32'(bus0.fault), 32'd1);
        bus0.op = 6'h00;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        chk("nom_add", bus0.out, 32'd7);
        chk("nom_add_fault", 32'(bus0.fault), 32'd0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/alu_mseq.md
# alu_mseq

Parametrised, handshaked successor to the single-cycle integer ALU. It executes every base integer/branch-compare operation with a one-cycle registered result, and adds iterative RV32M multiply/divide/remainder under a valid/ready protocol. It sits between operand fetch and writeback/branch resolution, and lets the core stall on long M operations.

## Interface
- WIDTH, 32, datapath width; power of two, at least 8; shift amount is in_b[$clog2(WIDTH)-1:0]
- ENABLE_M, 1, 1 enables the M operations; 0 makes every op[5]=1 code a fault
- clk  input  1  clock; all state changes on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block accepts a request this cycle
- op  input  6  operation code
- in_a  input  WIDTH  operand A; dividend/multiplicand
- in_b  input  WIDTH  operand B; divisor/multiplier
- out_valid  output  1  result present
- out_ready  input  1  consumer takes the result this cycle
- out  output  WIDTH  result
- fault  output  1  the op was invalid; qualified by out_valid

## Operation
- A request is accepted when in_valid & in_ready. op/in_a/in_b are sampled only at acceptance.
- Base ops (op[5]=0), 5-bit code op[4:0]:
  - 00000 ADD, 01000 SUB (a + ~b + 1), 00001 SLL, 00101 SRL, 01101 SRA
  - 00010 SLT, 00011 SLTU, 00100 XOR, 00110 OR, 00111 AND
  - 10000 BEQ, 10001 BNE, 10100 BLT, 10101 BGE, 10110 BLTU, 10111 BGEU
  - Compare and branch ops return zero-extended 0/1.
  - All other base codes fault.
- M ops (op[5]=1): op[4:3] must be 00, else fault. op[2:0] selects:
  - 000 MUL (low WIDTH bits), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high)
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU; quotient truncates toward zero, remainder takes the sign of the dividend
- Fault result: out=0, fault=1. fault=0 for every valid op.
- FSM states:
  - IDLE: in_ready=1. On accept: base/fault/special-case op goes to DONE; other M op goes to BUSY with count=0.
  - BUSY: in_ready=0. Radix-2 shift-add multiply or restoring divide on operand magnitudes, one bit per cycle. Internal product is 2×WIDTH bits. count increments each cycle; after iteration WIDTH-1, sign-correct the result and go to DONE.
  - DONE: out_valid=1. out and fault are held stable until out_ready. On out_ready: if in_valid, accept the new request (same routing as IDLE); else go to IDLE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready.
- Division special cases resolve at accept with no iteration:
  - b=0: DIV/DIVU return all ones; REM/REMU return a.
  - DIV/REM with a=most-negative and b=-1: DIV returns a, REM returns 0.
- Reset (asynchronous, any state, including mid-BUSY): state=IDLE, out=0, fault=0, out_valid=0, count=0, in_ready=1 once reset_n is released. An aborted operation never produces a result.

## Timing
- Accept at edge N:
  - Base, fault or division special case: out_valid=1 from edge N+1.
  - Other M op: out_valid=1 from edge N+WIDTH+1 (33 cycles at WIDTH=32).
- out_valid stays high until the edge where out_ready=1. The output changes only at that edge.
- Back-to-back: with out_ready held high and in_valid held high, base ops sustain one result per cycle.
- in_ready=0 for every BUSY cycle. in_valid during BUSY is ignored and not queued.
- out_ready while out_valid=0 has no effect.

## Test plan
- Base sweep (WIDTH=32, out_ready=1): ADD 7+5 -> 12; SUB 5-7 -> 0xFFFFFFFE; SRA 0x80000000 by 4 -> 0xF8000000; SLTU 1,0xFFFFFFFF -> 1; BGE -1,0 -> 0. Each result is valid one cycle after accept; one result per cycle back-to-back.
- MULH 0xFFFFFFFF × 0xFFFFFFFF -> 0; MULHU on the same operands -> 0xFFFFFFFE; MUL 3×-4 -> 0xFFFFFFF4. out_valid exactly 33 cycles after accept.
- DIV -7/2 -> 0xFFFFFFFD and REM -7/2 -> 0xFFFFFFFF, each after 33 cycles. DIVU 5/0 -> 0xFFFFFFFF and REM 0x80000000/-1 -> 0, each after 1 cycle.
- Faults: op=0x09, op=0x38, and op=0x20 with ENABLE_M=0 -> out=0, fault=1, 1-cycle latency. The next valid op returns fault=0.
- Backpressure: hold out_ready=0 for 5 cycles after a DIVU result. Require out/fault stable, in_ready=0 throughout, and in_valid ignored. Release -> the result is taken and in_ready=1 in the same cycle.
- Assert reset_n low at BUSY count=10 -> out_valid=0, out=0, fault=0 immediately. After release, ADD 1+1 -> 2 after 1 cycle, and the aborted result never appears.
